// File: rtl/conv_pkg.sv
// Shared types and constants for the conv window controller.
// Imported by line_buf and conv_window_ctrl.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_K,
        ST_STREAM,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] MODE_RSVD = 2'b11;
    localparam int KTAPS = 9;

endpackage

// File: rtl/conv_window_ctrl_line_buf.sv
// Two cascaded row buffers indexed by column.
// Reads return the value stored before this cycle's write.
module line_buf
    import conv_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int DW    = 8,
    localparam int CW   = $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [CW-1:0] col,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout1,
    output logic [DW-1:0] dout2
);

    logic [DW-1:0] mem1 [IMG_W];
    logic [DW-1:0] mem2 [IMG_W];

    assign dout1 = mem1[col];
    assign dout2 = mem2[col];

    // push the new pixel into row r-1, moving the old one to row r-2
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem1[col] <= din;
            mem2[col] <= mem1[col];
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// 3x3 window sequencer driving the comp unit over a raster frame.
// Optional perf counters: define CONV_WINDOW_CTRL_PERF_EN.
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int DW       = 8,
    parameter int COMP_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      cfg_mode,
    input  logic            kern_valid,
    input  logic [DW-1:0]   kern_data,
    input  logic            pix_valid,
    input  logic [DW-1:0]   pix_data,
    output logic            pix_ready,
    output logic [9*DW-1:0] win_img,
    output logic [9*DW-1:0] win_kern,
    output logic [1:0]      comp_select,
    input  logic [DW-1:0]   comp_sum,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic            out_eol,
    output logic            out_last,
    output logic            busy,
    output logic            err
`ifdef CONV_WINDOW_CTRL_PERF_EN
    ,
    output logic [15:0]     perf_cycles,
    output logic [15:0]     perf_stall
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t          state;
    logic [1:0]      mode_q;
    logic [3:0]      kcnt;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic [9*DW-1:0] kern_q;
    logic [9*DW-1:0] win_q;
    logic [DW-1:0]   lb1;
    logic [DW-1:0]   lb2;
    logic [3*DW-1:0] new_col;
    logic            accept;
    logic            at_eol;
    logic            win_vld;
    logic [COMP_LAT:0] pv_q;
    logic [COMP_LAT:0] pe_q;
    logic [COMP_LAT:0] pl_q;

    assign accept  = (state == ST_STREAM) && pix_valid;
    assign at_eol  = (col_q == COL_LAST);
    assign win_vld = accept && (row_q >= RW'(2))
                     && (col_q >= CW'(2));
    assign new_col = {pix_data, lb1, lb2};

    assign pix_ready   = (state == ST_STREAM);
    assign busy        = (state != ST_IDLE);
    assign comp_select = mode_q;
    assign win_img     = win_q;
    assign win_kern    = kern_q;
    assign out_valid   = pv_q[COMP_LAT];
    assign out_eol     = pe_q[COMP_LAT];
    assign out_last    = pl_q[COMP_LAT];
    assign out_data    = out_valid ? comp_sum : '0;

    line_buf #(
        .IMG_W (IMG_W),
        .DW    (DW)
    ) u_lb (
        .clk   (clk),
        .wr_en (accept),
        .col   (col_q),
        .din   (pix_data),
        .dout1 (lb1),
        .dout2 (lb2)
    );

    // frame sequencing: kernel load, pixel stream, drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mode_q <= 2'b00;
            err    <= 1'b0;
            kcnt   <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_mode == MODE_RSVD) begin
                            err <= 1'b1;
                        end else begin
                            err    <= 1'b0;
                            mode_q <= cfg_mode;
                            kcnt   <= '0;
                            col_q  <= '0;
                            row_q  <= '0;
                            state  <= ST_LOAD_K;
                        end
                    end
                end
                ST_LOAD_K: begin
                    if (kern_valid) begin
                        kcnt <= kcnt + 4'd1;
                        if (kcnt == 4'(KTAPS - 1))
                            state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (pix_valid) begin
                        if (at_eol) begin
                            col_q <= '0;
                            row_q <= row_q + RW'(1);
                            if (row_q == ROW_LAST)
                                state <= ST_DRAIN;
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_last)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // kernel taps written in arrival order, held until the next load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kern_q <= '0;
        end else if (state == ST_LOAD_K && kern_valid) begin
            kern_q[kcnt*DW +: DW] <= kern_data;
        end
    end

    // 3x3 window shifts left by one column per accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_q[(r*3)*DW +: DW]   <= win_q[(r*3+1)*DW +: DW];
                win_q[(r*3+1)*DW +: DW] <= win_q[(r*3+2)*DW +: DW];
                win_q[(r*3+2)*DW +: DW] <= new_col[r*DW +: DW];
            end
        end
    end

    // result markers ride alongside comp's latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            pe_q <= '0;
            pl_q <= '0;
        end else begin
            pv_q <= {pv_q[COMP_LAT-1:0], win_vld};
            pe_q <= {pe_q[COMP_LAT-1:0], win_vld && at_eol};
            pl_q <= {pl_q[COMP_LAT-1:0],
                     win_vld && at_eol && (row_q == ROW_LAST)};
        end
    end

`ifdef CONV_WINDOW_CTRL_PERF_EN
    // busy-cycle and stream-stall counters, saturating, cleared at start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (state == ST_IDLE) begin
            if (start && cfg_mode != MODE_RSVD) begin
                perf_cycles <= '0;
                perf_stall  <= '0;
            end
        end else begin
            if (perf_cycles != 16'hFFFF)
                perf_cycles <= perf_cycles + 16'd1;
            if (state == ST_STREAM && !pix_valid
                && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
        end
    end
`else
    // no performance counters in this build
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl.
// Two instances: 4x4 with COMP_LAT=1 and 5x5 with COMP_LAT=3.
module tb_conv_window_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic rst_n;

    logic        start1, kv1, pv1, pr1, ov1, oe1, ol1, busy1, err1;
    logic [1:0]  mode1, sel1;
    logic [7:0]  kd1, pd1, cs1, od1;
    logic [71:0] wi1, wk1;

    logic        start2, kv2, pv2, pr2, ov2, oe2, ol2, busy2, err2;
    logic [1:0]  mode2, sel2;
    logic [7:0]  kd2, pd2, cs2, od2;
    logic [71:0] wi2, wk2;

`ifdef CONV_WINDOW_CTRL_PERF_EN
    logic [15:0] pc1, ps1, pc2, ps2;
`endif

    conv_window_ctrl #(
        .IMG_W(4), .IMG_H(4), .DW(8), .COMP_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .cfg_mode(mode1), .kern_valid(kv1), .kern_data(kd1),
        .pix_valid(pv1), .pix_data(pd1), .pix_ready(pr1),
        .win_img(wi1), .win_kern(wk1), .comp_select(sel1),
        .comp_sum(cs1), .out_valid(ov1), .out_data(od1),
        .out_eol(oe1), .out_last(ol1), .busy(busy1), .err(err1)
`ifdef CONV_WINDOW_CTRL_PERF_EN
        , .perf_cycles(pc1), .perf_stall(ps1)
`endif
    );

    conv_window_ctrl #(
        .IMG_W(5), .IMG_H(5), .DW(8), .COMP_LAT(3)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .cfg_mode(mode2), .kern_valid(kv2), .kern_data(kd2),
        .pix_valid(pv2), .pix_data(pd2), .pix_ready(pr2),
        .win_img(wi2), .win_kern(wk2), .comp_select(sel2),
        .comp_sum(cs2), .out_valid(ov2), .out_data(od2),
        .out_eol(oe2), .out_last(ol2), .busy(busy2), .err(err2)
`ifdef CONV_WINDOW_CTRL_PERF_EN
        , .perf_cycles(pc2), .perf_stall(ps2)
`endif
    );

    // comp stand-in: 00 dot product, 01 pixel sum, 10 max pixel
    function automatic logic [7:0] comp_fn(
        input logic [71:0] w, input logic [71:0] k,
        input logic [1:0] s);
        int acc;
        logic [7:0] mx;
        acc = 0;
        mx = 8'd0;
        for (int t = 0; t < 9; t++) begin
            if (s == 2'b00) acc += int'(w[t*8 +: 8]) * int'(k[t*8 +: 8]);
            if (s == 2'b01) acc += int'(w[t*8 +: 8]);
            if (w[t*8 +: 8] > mx) mx = w[t*8 +: 8];
        end
        return (s == 2'b10) ? mx : acc[7:0];
    endfunction

    logic [7:0] c2 [3];
    always @(posedge clk) begin
        cs1   <= comp_fn(wi1, wk1, sel1);
        c2[0] <= comp_fn(wi2, wk2, sel2);
        c2[1] <= c2[0];
        c2[2] <= c2[1];
    end
    assign cs2 = c2[2];

    typedef struct packed {
        logic [7:0]  d;
        logic        eol;
        logic        last;
        logic [31:0] cyc;
    } rec_t;

    rec_t q1[$];
    rec_t q2[$];

    always @(negedge clk) begin
        if (ov1) q1.push_back('{od1, oe1, ol1, cyc});
        if (ov2) q2.push_back('{od2, oe2, ol2, cyc});
    end

    typedef struct packed {
        logic [1:0]  mode;
        logic        toggle;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [4];

    localparam logic [71:0] KERN_EXP = 72'h09_08_07_06_05_04_03_02_01;
    localparam logic [71:0] WIN0_EXP = 72'h0B_0A_09_07_06_05_03_02_01;

    task automatic check(input string nm,
                         input logic [71:0] act,
                         input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start1_pulse(input logic [1:0] m);
        @(negedge clk);
        start1 = 1'b1;
        mode1  = m;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic load_kernel1();
        for (int k = 0; k < 9; k++) begin
            kv1 = 1'b1;
            kd1 = 8'(k + 1);
            @(negedge clk);
        end
        kv1 = 1'b0;
    endtask

    task automatic run_pixels1(input logic toggle, input int stop);
        int i;
        int n;
        logic acc;
        i = 0;
        n = 0;
        while (i < stop && n < 100) begin
            start1 = (n == 3);
            if (start1) mode1 = 2'b01;
            kv1 = (n == 5);
            kd1 = 8'hFF;
            if (toggle && n % 2 == 1) begin
                pv1 = 1'b0;
            end else begin
                pv1 = 1'b1;
                pd1 = 8'(i + 1);
            end
            acc = pv1 && pr1;
            @(negedge clk);
            n++;
            if (acc) begin
                i++;
                if (i == 11) check("first_window", wi1, WIN0_EXP);
            end
        end
        pv1 = 1'b0;
        start1 = 1'b0;
        kv1 = 1'b0;
        check("pixels_accepted", 72'(i), 72'(stop));
    endtask

    task automatic wait_idle1();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy1 && n < 50);
        check("idle_reached", busy1, 1'b0);
        if (q1.size() > 0)
            check("busy_fall", 72'(cyc), 72'(q1[q1.size()-1].cyc + 1));
    endtask

    task automatic run_vec(input vec_t v);
        q1.delete();
        start1_pulse(v.mode);
        check("err_clear", err1, 1'b0);
        check("busy_up", busy1, 1'b1);
        load_kernel1();
        check("win_kern", wk1, KERN_EXP);
        check("comp_select", sel1, v.mode);
        run_pixels1(v.toggle, 16);
        wait_idle1();
        check("kern_hold", wk1, KERN_EXP);
        check("mode_hold", sel1, v.mode);
        check("n_results", 72'(q1.size()), 72'd4);
        for (int j = 0; j < 4; j++) begin
            if (j < q1.size()) begin
                check("res_data", q1[j].d, v.exp[j*8 +: 8]);
                check("res_eol", q1[j].eol, (j % 2 == 1));
                check("res_last", q1[j].last, (j == 3));
            end
        end
    endtask

    initial begin
        int n;
        rec_t e2[$];

        vecs[0] = '{2'b00, 1'b0, 32'h3D_10_89_5C};
        vecs[1] = '{2'b00, 1'b1, 32'h3D_10_89_5C};
        vecs[2] = '{2'b01, 1'b0, 32'h63_5A_3F_36};
        vecs[3] = '{2'b10, 1'b1, 32'h10_0F_0C_0B};

        rst_n = 1'b0;
        {start1, kv1, pv1, start2, kv2, pv2} = '0;
        {mode1, mode2} = '0;
        {kd1, pd1, kd2, pd2} = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy1, 1'b0);
        check("rst_ready", pr1, 1'b0);
        check("rst_out_valid", ov1, 1'b0);
        check("rst_out_flags", {oe1, ol1}, 2'b00);
        check("rst_err", err1, 1'b0);
        check("rst_win_kern", wk1, 72'd0);
        check("rst_select", sel1, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        run_vec(vecs[0]);
`ifdef CONV_WINDOW_CTRL_PERF_EN
        check("perf_stall", ps1, 16'd0);
        check("perf_cycles", pc1, 16'd27);
`endif
        run_vec(vecs[1]);

        start1_pulse(2'b11);
        check("err_set", err1, 1'b1);
        check("err_busy", busy1, 1'b0);
        @(negedge clk);
        check("err_sticky", err1, 1'b1);
        run_vec(vecs[3]);
        run_vec(vecs[2]);

        q1.delete();
        start1_pulse(2'b00);
        load_kernel1();
        run_pixels1(1'b0, 10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_busy", busy1, 1'b0);
        check("mid_rst_ready", pr1, 1'b0);
        check("mid_rst_valid", ov1, 1'b0);
        check("mid_rst_kern", wk1, 72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_rst_no_out", 72'(q1.size()), 72'd0);
        run_vec(vecs[0]);

        q2.delete();
        @(negedge clk);
        start2 = 1'b1;
        mode2  = 2'b01;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            kv2 = 1'b1;
            kd2 = 8'd1;
            @(negedge clk);
        end
        kv2 = 1'b0;
        for (int i = 0; i < 25; i++) begin
            pv2 = 1'b1;
            pd2 = 8'(i + 1);
            if (i / 5 >= 2 && i % 5 >= 2)
                e2.push_back('{8'(9 * (5 * (i / 5 - 2) + i % 5 - 1) + 54),
                               (i % 5 == 4), (i == 24), 32'(cyc + 4)});
            check("s2_ready", pr2, 1'b1);
            @(negedge clk);
        end
        pv2 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy2 && n < 50);
        check("s2_idle", busy2, 1'b0);
        check("s2_n_results", 72'(q2.size()), 72'd9);
        for (int j = 0; j < 9; j++) begin
            if (j < q2.size()) check("s2_result", 72'(q2[j]), 72'(e2[j]));
        end
        if (q2.size() > 0)
            check("s2_busy_fall", 72'(cyc),
                  72'(q2[q2.size()-1].cyc + 1));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Streaming controller that sequences the 3x3 `comp` compute unit over a full image. It does three things:
- loads a 3x3 kernel;
- accepts raster-order pixels through a valid/ready handshake, building each 3x3 window from two line buffers;
- drives `comp` with the window, kernel and operation select, and returns one result per valid window with row/frame markers.

It sits between the pixel source (image memory/DMA) and the `comp` instance.

## Interface
- `IMG_W`, 8: image width in pixels, ≥3
- `IMG_H`, 8: image height in rows, ≥3
- `DW`, 8: pixel/kernel/result width
- `COMP_LAT`, 1: `comp` latency in clocks from window inputs to `sum`
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse; begins a frame, sampled only in IDLE
- `cfg_mode` in 2: operation select, latched at `start`; 2'b11 is reserved
- `kern_valid` in 1, `kern_data` in DW: kernel tap stream, taps 0..8
- `pix_valid` in 1, `pix_data` in DW, `pix_ready` out 1: pixel stream handshake
- `win_img` out 9*DW: image taps; tap k occupies bits [k*DW +: DW], tap 0 = top-left, row-major
- `win_kern` out 9*DW: kernel taps, same packing
- `comp_select` out 2: to `comp` select
- `comp_sum` in DW: from `comp` sum
- `out_valid` out 1, `out_data` out DW: result stream, no backpressure
- `out_eol` out 1: last result of an output row
- `out_last` out 1: last result of the frame
- `busy` out 1: high when the state is not IDLE
- `err` out 1: sticky reserved-mode flag

## Operation
- FSM states: IDLE → LOAD_K → STREAM → DRAIN → IDLE.
- IDLE:
  - `start` with `cfg_mode`≠11: latch the mode, clear the counters, go to LOAD_K.
  - `start` with `cfg_mode`=11: set `err`, stay in IDLE.
  - `err` clears on the next accepted `start`.
- LOAD_K:
  - Each `kern_valid` cycle writes `kern_data` to the tap counter slot (0..8).
  - After tap 8, go to STREAM.
  - `pix_ready`=0 throughout.
- STREAM:
  - `pix_ready`=1. Each accepted pixel advances `col` (0..IMG_W-1), wrapping to 0 and incrementing `row`.
  - Two line buffers of IMG_W entries hold rows r-1 and r-2. A 3x3 shift window takes column taps {lb2[col], lb1[col], pix}.
  - A window is valid when `row`≥2 and `col`≥2 (no padding, stride 1). Each frame yields (IMG_W-2)*(IMG_H-2) results.
  - Accepting pixel (IMG_W-1, IMG_H-1) moves the FSM to DRAIN.
- DRAIN: wait until the final result has left the COMP_LAT delay line, then go to IDLE.
- `win_kern` is held constant from the end of LOAD_K until the next load.
- `comp_select` = the latched mode.
- `win_img` holds the last window between acceptances.
- `out_data` = `comp_sum` (pass-through, no width change). `out_eol` and `out_last` travel with `out_valid` in the delay line.

## Timing
- Reset values:
  - all outputs 0, state IDLE;
  - line buffers and window need not be reset;
  - `win_kern` resets to 0.
- Pixel accepted at edge t, completing a valid window:
  - `win_img` shows that window after edge t;
  - `out_valid` is high in the cycle after edge t+COMP_LAT.
- Throughput: one pixel per clock; `pix_valid` may drop at any time, and the window does not advance without acceptance.
- `start` outside IDLE is ignored.
- `kern_valid` outside LOAD_K is ignored.
- `pix_valid` outside STREAM is not accepted.
- Reset mid-frame: the FSM returns to IDLE immediately, counters clear and the in-flight results are dropped (`out_valid` forced 0).
- `busy` falls in the same cycle the FSM enters IDLE, after the final `out_valid`.

## Configuration
- `CONV_WINDOW_CTRL_PERF_EN` defined:
  - adds output port `perf_cycles` (16 bits), which counts clocks from the accepted `start` to the return to IDLE, saturates at 16'hFFFF, and holds until the next `start`;
  - also adds `perf_stall` (16 bits), which counts STREAM cycles with `pix_valid`=0.
- Undefined: both ports and both counters are absent.

## Structure
- Package `conv_pkg` holds:
  - the FSM state enum (`ST_IDLE`, `ST_LOAD_K`, `ST_STREAM`, `ST_DRAIN`);
  - `MODE_RSVD` = 2'b11;
  - the `KTAPS` = 9 constant.
- Sub-module `line_buf` (parameters IMG_W, DW): two cascaded row FIFOs indexed by `col`; read before write in the same cycle.

## Test plan
- Kernel 1..9, 4x4 frame of pixels 1..16, mode 00:
  - `win_kern` = {1..9};
  - first window `win_img` = {1,2,3,5,6,7,9,10,11};
  - 4 results;
  - `out_eol` on results 2 and 4; `out_last` on result 4.
- Same frame with `pix_valid` toggled every other cycle: identical windows and results, only spread in time.
- `start` with `cfg_mode`=11: `err`=1, `busy` stays 0; a following `start` with mode 10 clears `err` and the frame runs with `comp_select`=10.
- Assert `rst_n` after pixel 10 of a 4x4 frame: outputs 0, IDLE next cycle; a fresh frame then produces 4 correct results.
- COMP_LAT=3, 5x5 frame: 9 results, each `out_valid` 4 cycles after the completing pixel; `busy` falls right after the last result.
- With `CONV_WINDOW_CTRL_PERF_EN`, 4x4 frame with no stalls: `perf_stall`=0 and `perf_cycles` = kernel cycles + 16 + drain.
